// File: rtl/if_prefetch_queue_if.sv
// Instruction-cache request bus between the fetch stage (master) and the i-cache (slave).
interface if_prefetch_queue_if #(
   parameter int XLEN = 32
);
   logic            IMEM_READ;
   logic [XLEN-1:0] IMEM_ADDR;
   logic [XLEN-1:0] IMEM_INSTR;
   logic            IMEM_BUSYWAIT;

   modport master (output IMEM_READ, IMEM_ADDR, input IMEM_INSTR, IMEM_BUSYWAIT);
   modport slave  (input IMEM_READ, IMEM_ADDR, output IMEM_INSTR, IMEM_BUSYWAIT);
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: sequential i-cache fetch into a DEPTH-entry {PC, INSTRUCTION} queue,
// flushed on branch redirect; an access caught in flight by a redirect is drained and dropped.
module if_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       LU_HAZARD,
   input  logic                       MEM_BUSYWAIT,
   input  logic                       BRANCH_SEL,
   input  logic [XLEN-1:0]            B_PC,
   if_prefetch_queue_if.master        imem,
   output logic                       IF_VALID,
   output logic [XLEN-1:0]            PC,
   output logic [XLEN-1:0]            INSTRUCTION,
   output logic [$clog2(DEPTH+1)-1:0] QUEUE_COUNT
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {S_FETCH, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic            pend_q;
   logic [XLEN-1:0] fetch_pc, drain_addr;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] pc_mem  [DEPTH];
   logic [XLEN-1:0] ins_mem [DEPTH];

   logic rd, done, pop, push, redirect;

   assign IF_VALID    = (count != '0);
   assign QUEUE_COUNT = count;
   assign PC          = IF_VALID ? pc_mem[rd_ptr]  : '0;
   assign INSTRUCTION = IF_VALID ? ins_mem[rd_ptr] : '0;

   assign pop      = IF_VALID & ~LU_HAZARD & ~MEM_BUSYWAIT;
   assign redirect = BRANCH_SEL & ~MEM_BUSYWAIT;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // A stalled request (pend_q) keeps IMEM_READ up even if the pop that launched it goes away.
   always_comb begin
      state_d = state_q;
      rd      = 1'b0;
      imem.IMEM_ADDR = fetch_pc;
      case (state_q)
         S_FETCH: begin
            rd = ~RESET & (pend_q | (count < FULL) | pop);
            if (redirect & rd & imem.IMEM_BUSYWAIT) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            rd = ~RESET;
            imem.IMEM_ADDR = drain_addr;
            if (rd & ~imem.IMEM_BUSYWAIT) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      imem.IMEM_READ = rd;
      done = rd & ~imem.IMEM_BUSYWAIT;
      push = done & (state_q == S_FETCH) & ~redirect;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_pc   <= RESET_PC;
         drain_addr <= RESET_PC;
         pend_q     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         pend_q <= (state_q == S_FETCH) & rd & imem.IMEM_BUSYWAIT & ~redirect;
         if (redirect) begin
            fetch_pc <= B_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // Only the first redirect captures the in-flight address; later ones retarget only.
            if (state_q == S_FETCH) drain_addr <= fetch_pc;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + AW'(1);
               fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         pc_mem[wr_ptr]  <= fetch_pc;
         ins_mem[wr_ptr] <= imem.IMEM_INSTR;
      end
   end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed vector table, reset-mid-access sequence, and a randomized
// run against a queue-based reference model of the fetch stage.
module tb_if_prefetch_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic            CLK = 1'b0;
   logic            RESET, lu, mb, br, ib;
   logic [XLEN-1:0] bpc;
   logic            IF_VALID;
   logic [XLEN-1:0] PC, INSTRUCTION;
   logic [CW-1:0]   QUEUE_COUNT;
   int              npass = 0, ntot = 0;

   if_prefetch_queue_if #(.XLEN(XLEN)) imem ();
   assign imem.IMEM_INSTR    = imem.IMEM_ADDR ^ 32'h5A5A_0000;
   assign imem.IMEM_BUSYWAIT = ib;

   if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(4)) dut (
      .CLK(CLK), .RESET(RESET), .LU_HAZARD(lu), .MEM_BUSYWAIT(mb), .BRANCH_SEL(br),
      .B_PC(bpc), .imem(imem), .IF_VALID(IF_VALID), .PC(PC), .INSTRUCTION(INSTRUCTION),
      .QUEUE_COUNT(QUEUE_COUNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic set_in(input logic l, input logic m, input logic b, input logic [31:0] bp,
                         input logic i);
      lu = l; mb = m; br = b; bpc = bp; ib = i;
   endtask

   // Leaves the bench at a negedge with RESET just released.
   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("reset_read", 32'(imem.IMEM_READ), 0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   typedef struct {
      logic        lu, mb, br;
      logic [31:0] bpc;
      logic        ib;
      logic        v;
      logic [31:0] pc;
      int          cnt;
      logic        rd;
      logic [31:0] addr;
   } vec_t;

   vec_t vt[18];

   // Reference model state
   logic [31:0] mq[$];
   logic [31:0] m_fpc, m_dad;
   bit          m_drain, m_pend;

   initial begin
      RESET = 1'b1;
      set_in(0, 0, 0, 0, 0);
      //         lu mb br bpc      ib  v  pc        cnt rd addr
      vt[0]  = '{0, 0, 0, 0,       0,  0, 0,        0,  1, 32'h0};
      vt[1]  = '{0, 0, 0, 0,       0,  1, 32'h0,    1,  1, 32'h4};
      vt[2]  = '{0, 0, 0, 0,       0,  1, 32'h4,    1,  1, 32'h8};
      vt[3]  = '{1, 0, 0, 0,       0,  1, 32'h8,    1,  1, 32'hC};
      vt[4]  = '{1, 0, 0, 0,       0,  1, 32'h8,    2,  1, 32'h10};
      vt[5]  = '{1, 0, 0, 0,       0,  1, 32'h8,    3,  1, 32'h14};
      vt[6]  = '{1, 0, 0, 0,       0,  1, 32'h8,    4,  0, 32'h18};
      vt[7]  = '{0, 0, 0, 0,       0,  1, 32'h8,    4,  1, 32'h18};
      vt[8]  = '{0, 0, 0, 0,       0,  1, 32'hC,    4,  1, 32'h1C};
      vt[9]  = '{0, 1, 1, 32'h100, 0,  1, 32'h10,   4,  0, 32'h20};
      vt[10] = '{0, 0, 1, 32'h100, 0,  1, 32'h10,   4,  1, 32'h20};
      vt[11] = '{0, 0, 0, 0,       0,  0, 0,        0,  1, 32'h100};
      vt[12] = '{0, 0, 0, 0,       1,  1, 32'h100,  1,  1, 32'h104};
      vt[13] = '{0, 0, 1, 32'h200, 1,  0, 0,        0,  1, 32'h104};
      vt[14] = '{0, 0, 0, 0,       1,  0, 0,        0,  1, 32'h104};
      vt[15] = '{0, 0, 0, 0,       0,  0, 0,        0,  1, 32'h104};
      vt[16] = '{0, 0, 0, 0,       0,  0, 0,        0,  1, 32'h200};
      vt[17] = '{0, 0, 0, 0,       0,  1, 32'h200,  1,  1, 32'h204};

      do_reset();
      foreach (vt[k]) begin
         set_in(vt[k].lu, vt[k].mb, vt[k].br, vt[k].bpc, vt[k].ib);
         #1;
         chk($sformatf("v%0d_valid", k), 32'(IF_VALID), 32'(vt[k].v));
         chk($sformatf("v%0d_pc", k), PC, vt[k].pc);
         chk($sformatf("v%0d_instr", k), INSTRUCTION, vt[k].v ? idata(vt[k].pc) : 32'h0);
         chk($sformatf("v%0d_count", k), 32'(QUEUE_COUNT), 32'(vt[k].cnt));
         chk($sformatf("v%0d_read", k), 32'(imem.IMEM_READ), 32'(vt[k].rd));
         chk($sformatf("v%0d_addr", k), imem.IMEM_ADDR, vt[k].addr);
         @(negedge CLK);
      end

      // Reset while an i-cache access is stalled with a non-empty queue.
      set_in(1, 0, 0, 0, 0);
      repeat (2) @(negedge CLK);
      set_in(1, 0, 0, 0, 1);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("rst_mid_read", 32'(imem.IMEM_READ), 0);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(IF_VALID), 0);
      chk("rst_mid_count", 32'(QUEUE_COUNT), 0);
      chk("rst_mid_addr", imem.IMEM_ADDR, 32'h0);
      chk("rst_mid_pc", PC, 32'h0);
      @(negedge CLK);

      // Randomized run against the reference model.
      do_reset();
      mq.delete();
      m_fpc = 0; m_dad = 0; m_drain = 0; m_pend = 0;
      for (int blk = 0; blk < 15; blk++) begin
         int hz_pct = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 40 : 80;
         for (int c = 0; c < 200; c++) begin
            bit pop, rd, done, redir;
            logic [31:0] eaddr;
            int sz;
            set_in($urandom_range(0, 99) < hz_pct, $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 5, {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                   $urandom_range(0, 99) < 30);
            #1;
            sz    = mq.size();
            pop   = (sz > 0) && !lu && !mb;
            rd    = m_drain || m_pend || (sz < DEPTH) || pop;
            eaddr = m_drain ? m_dad : m_fpc;
            done  = rd && !ib;
            redir = br && !mb;
            chk("rnd_valid", 32'(IF_VALID), 32'(sz > 0));
            chk("rnd_count", 32'(QUEUE_COUNT), 32'(sz));
            chk("rnd_pc", PC, (sz > 0) ? mq[0] : 32'h0);
            chk("rnd_instr", INSTRUCTION, (sz > 0) ? idata(mq[0]) : 32'h0);
            chk("rnd_read", 32'(imem.IMEM_READ), 32'(rd));
            if (rd) chk("rnd_addr", imem.IMEM_ADDR, eaddr);
            if (redir) begin
               mq.delete();
               if (rd && ib) begin
                  if (!m_drain) m_dad = m_fpc;
                  m_drain = 1;
               end else begin
                  m_drain = 0;
               end
               m_fpc  = bpc;
               m_pend = 0;
            end else if (m_drain) begin
               if (done) m_drain = 0;
               m_pend = 0;
            end else begin
               if (pop) void'(mq.pop_front());
               if (done) begin
                  mq.push_back(m_fpc);
                  m_fpc = m_fpc + 4;
               end
               m_pend = rd && ib;
            end
            @(negedge CLK);
         end
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
